dcache_sa_wb: RTL and testbench
===============================

DCACHE_SA_WB -- requirements
Module: dcache_sa_wb

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32: CPU word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_LENGTH, default 32: address width.
REQ-003 SHALL have parameter LINE_BITS, default 128: line width, equal to the memory bus width, a multiple of DATA_LENGTH.
REQ-004 SHALL have parameter SETS, default 64: number of sets, a power of two.
REQ-005 SHALL have parameter WAYS, default 2: associativity, a power of two from 1 to 8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have ports valid, rw, addr, wdata and wmask, inputs of widths 1, 1, ADDR_LENGTH, DATA_LENGTH and DATA_LENGTH: the CPU request; rw=1 is a write; wmask is a bit mask.
REQ-009 SHALL have ports ready, rvalid and rdata, outputs of widths 1, 1 and DATA_LENGTH: the CPU response.
REQ-010 SHALL have ports mem_req_valid, mem_req_rw, mem_req_addr and mem_req_data, outputs of widths 1, 1, ADDR_LENGTH and LINE_BITS: the memory request.
REQ-011 SHALL have ports mem_res_ready and mem_res_data, inputs of widths 1 and LINE_BITS: the memory response.
REQ-012 SHALL have ports hit_count and miss_count, outputs, 32 bits each: saturating statistics counters.

Function
REQ-013 SHALL split the address into offset = log2(LINE_BITS/8) bits, index = log2(SETS) bits and tag = the remaining bits, from LSB upward.
REQ-014 SHALL hold per way and set: valid, dirty and tag bits plus one line; data and tag arrays SHALL have asynchronous read and synchronous write.
REQ-015 SHALL keep a per-set round-robin victim pointer of log2(WAYS) bits.
REQ-016 SHALL implement the states IDLE, COMPARE, WRITE_BACK and ALLOCATE.
REQ-017 SHALL accept a request when valid && ready, latching addr, wdata, wmask and rw, and SHALL move to COMPARE.
REQ-018 In IDLE, ready SHALL be 1 and rvalid SHALL be 0.
REQ-019 A hit SHALL mean any way in the latched set has valid=1 and a matching tag.
REQ-020 On a hit in COMPARE, rvalid and ready SHALL be 1 in the same cycle, and rdata SHALL be the addressed word of the hit way (hit latency 1 cycle after acceptance).
REQ-021 On a write hit, the word SHALL become (old & ~wmask) | (wdata & wmask) and the way SHALL be marked dirty at the next edge.
REQ-022 On a hit, the next state SHALL be COMPARE if a new request is accepted that cycle, otherwise IDLE (back-to-back hits at one per cycle).
REQ-023 On a miss in COMPARE, ready and rvalid SHALL be 0.
REQ-024 On a miss, the victim SHALL be the lowest-index invalid way; if all ways are valid, the victim SHALL be the way named by the set's round-robin pointer.
REQ-025 On a miss with a clean victim, the block SHALL issue a read (rw=0) at the line-aligned latched addr and go to ALLOCATE.
REQ-026 On a miss with a dirty victim, the block SHALL issue a write (rw=1) at {victim tag, index, offset 0} carrying the victim line, and go to WRITE_BACK.
REQ-027 mem_req_valid and its payload SHALL be held stable from issue until the cycle mem_res_ready=1 inclusive.
REQ-028 In WRITE_BACK, on mem_res_ready the block SHALL issue the line read and go to ALLOCATE.
REQ-029 In ALLOCATE, on mem_res_ready the block SHALL write mem_res_data into the victim way with valid=1, dirty=0 and the new tag, advance that set's pointer modulo WAYS if no way was invalid, and return to COMPARE, which then hits.
REQ-030 hit_count SHALL increment once per hit cycle in COMPARE whose request was not just refilled.
REQ-031 miss_count SHALL increment once per miss detection.
REQ-032 Both counters SHALL saturate at 0xFFFF_FFFF.
REQ-033 When a write hit and acceptance of a same-address read occur in one cycle, the read SHALL return the newly written data.
REQ-034 WAYS=1 SHALL degrade to direct-mapped, with the pointer constant 0.

Reset
REQ-035 While rst_n=0, the block SHALL immediately force state=IDLE, clear every valid and dirty bit, and set all victim pointers and both counters to 0.
REQ-036 While rst_n=0, outputs SHALL be: ready=0, rvalid=0, rdata=0, mem_req_valid=0, mem_req_rw=0.
REQ-037 Reset during WRITE_BACK or ALLOCATE SHALL abandon the transaction, and any mem_res_ready that arrives later SHALL be ignored in IDLE.
REQ-038 Data array contents SHALL be undefined after reset.

Verification (defaults: 2-way, 64 sets, 128-bit lines; index = addr[9:4])
REQ-039 Cold read of 0x100 -> mem read at 0x100; respond with word0=0x11111111 -> rvalid=1 and rdata=0x11111111 one cycle after mem_res_ready; miss_count=1.
REQ-040 Reads of 0x100 then 0x104 on consecutive cycles -> rvalid on consecutive cycles, no mem_req_valid, hit_count=2.
REQ-041 Write 0x100 with wdata=0xAB, wmask=0x000000FF, then read 0x100 -> rdata=0x111111AB.
REQ-042 After 0x100 (dirty) and 0x500 fill set 16, read 0x900 -> mem write at 0x100 whose word0=0x111111AB, then mem read at 0x900, with way 0 replaced.
REQ-043 rst_n low mid-ALLOCATE -> mem_req_valid=0 immediately; after release, a read of 0x100 misses.
REQ-044 Write 0x104=0x22 (wmask 0xFFFFFFFF) hitting while a read of 0x104 is accepted the same cycle -> the read returns 0x22.

Source files
------------

// File: rtl/dcache_sa_wb.sv
// Set-associative write-back data cache with write-allocate and per-set round-robin replacement.
// The CPU side takes one request per valid&&ready; the memory side issues one line transfer at a time.
module dcache_sa_wb #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int LINE_BITS   = 128,
  parameter int SETS        = 64,
  parameter int WAYS        = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid,
  input  logic                   rw,
  input  logic [ADDR_LENGTH-1:0] addr,
  input  logic [DATA_LENGTH-1:0] wdata,
  input  logic [DATA_LENGTH-1:0] wmask,
  output logic                   ready,
  output logic                   rvalid,
  output logic [DATA_LENGTH-1:0] rdata,
  output logic                   mem_req_valid,
  output logic                   mem_req_rw,
  output logic [ADDR_LENGTH-1:0] mem_req_addr,
  output logic [LINE_BITS-1:0]   mem_req_data,
  input  logic                   mem_res_ready,
  input  logic [LINE_BITS-1:0]   mem_res_data,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic [1:0]             dbg_state_o
);

  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_LENGTH - OFF_W - IDX_W;
  localparam int WORDS  = LINE_BITS / DATA_LENGTH;
  localparam int BYTE_W = $clog2(DATA_LENGTH / 8);
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   req_rw_q;
  logic [ADDR_LENGTH-1:0] req_addr_q;
  logic [DATA_LENGTH-1:0] req_wdata_q;
  logic [DATA_LENGTH-1:0] req_wmask_q;
  logic                   mem_req_valid_q;
  logic                   mem_req_rw_q;
  logic [ADDR_LENGTH-1:0] mem_req_addr_q;
  logic [LINE_BITS-1:0]   mem_req_data_q;
  logic [PTR_W-1:0]       victim_q;
  logic                   victim_free_q;
  logic                   refilled_q;
  logic [31:0]            hit_count_q;
  logic [31:0]            miss_count_q;

  logic [WAYS-1:0][SETS-1:0]  valid_q;
  logic [WAYS-1:0][SETS-1:0]  dirty_q;
  logic [SETS-1:0][PTR_W-1:0] rr_q;
  logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
  logic [LINE_BITS-1:0]       data_q [WAYS][SETS];

  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic [WSEL_W-1:0]      word_sel;
  logic [ADDR_LENGTH-1:0] line_addr;

  assign req_idx   = req_addr_q[OFF_W +: IDX_W];
  assign req_tag   = req_addr_q[ADDR_LENGTH-1 -: TAG_W];
  assign word_sel  = WSEL_W'(req_addr_q[OFF_W-1:0] >> BYTE_W);
  assign line_addr = {req_tag, req_idx, {OFF_W{1'b0}}};

  logic             hit;
  logic [PTR_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; scanning downward lets the last match be the lowest.
  logic [PTR_W-1:0] victim;
  logic             victim_free;

  always_comb begin
    victim      = rr_q[req_idx];
    victim_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        victim      = PTR_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  logic victim_dirty;
  assign victim_dirty = valid_q[victim][req_idx] & dirty_q[victim][req_idx];

  logic [LINE_BITS-1:0]   hit_line;
  logic [LINE_BITS-1:0]   wr_line;
  logic [DATA_LENGTH-1:0] rd_word;

  assign hit_line = data_q[hit_way][req_idx];

  always_comb begin
    rd_word = '0;
    wr_line = hit_line;
    for (int k = 0; k < WORDS; k++) begin
      if (WSEL_W'(k) == word_sel) begin
        rd_word = hit_line[k*DATA_LENGTH +: DATA_LENGTH];
        wr_line[k*DATA_LENGTH +: DATA_LENGTH] = (rd_word & ~req_wmask_q) | (req_wdata_q & req_wmask_q);
      end
    end
  end

  // CPU handshake: a request transfers on any rising edge where valid && ready; ready is high
  // only in IDLE or on a COMPARE hit, so a hit cycle can also take the next request.
  logic cmp_hit;
  logic accept;
  logic fill;
  logic wr_hit;

  assign cmp_hit = (state_q == COMPARE) & hit;
  assign ready   = rst_n & ((state_q == IDLE) | cmp_hit);
  assign accept  = valid & ready;
  assign fill    = (state_q == ALLOCATE) & mem_res_ready;
  assign wr_hit  = cmp_hit & req_rw_q;

  assign rvalid        = cmp_hit;
  assign rdata         = cmp_hit ? rd_word : '0;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  assign dbg_state_o   = state_q;

  // Line and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[victim_q][req_idx] <= mem_res_data;
      tag_q[victim_q][req_idx]  <= req_tag;
    end else if (wr_hit) begin
      data_q[hit_way][req_idx] <= wr_line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_rw_q        <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_wmask_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      victim_q        <= '0;
      victim_free_q   <= 1'b0;
      refilled_q      <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
      rr_q            <= '0;
    end else begin
      if (accept) begin
        req_rw_q    <= rw;
        req_addr_q  <= addr;
        req_wdata_q <= wdata;
        req_wmask_q <= wmask;
        refilled_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) state_q <= COMPARE;
        end

        COMPARE: begin
          if (hit) begin
            if (req_rw_q) dirty_q[hit_way][req_idx] <= 1'b1;
            if (!refilled_q && (hit_count_q != '1)) hit_count_q <= hit_count_q + 32'd1;
            state_q <= accept ? COMPARE : IDLE;
          end else begin
            if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
            victim_q        <= victim;
            victim_free_q   <= victim_free;
            mem_req_valid_q <= 1'b1;
            if (victim_dirty) begin
              mem_req_rw_q   <= 1'b1;
              mem_req_addr_q <= {tag_q[victim][req_idx], req_idx, {OFF_W{1'b0}}};
              mem_req_data_q <= data_q[victim][req_idx];
              state_q        <= WRITE_BACK;
            end else begin
              mem_req_rw_q   <= 1'b0;
              mem_req_addr_q <= line_addr;
              state_q        <= ALLOCATE;
            end
          end
        end

        WRITE_BACK: begin
          if (mem_res_ready) begin
            mem_req_rw_q   <= 1'b0;
            mem_req_addr_q <= line_addr;
            state_q        <= ALLOCATE;
          end
        end

        ALLOCATE: begin
          if (mem_res_ready) begin
            mem_req_valid_q            <= 1'b0;
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
            if (!victim_free_q && (WAYS > 1)) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
            refilled_q <= 1'b1;
            state_q    <= COMPARE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Bench for dcache_sa_wb: directed scenarios then random traffic, checked against an
// architectural memory image plus a tag/replacement model of the cache.
module tb_dcache_sa_wb;

  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  wmask = '0;
  logic         ready;
  logic         rvalid;
  logic [31:0]  rdata;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_res_ready = 1'b0;
  logic [127:0] mem_res_data = '0;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
  logic [1:0]   dbg_state;

  dcache_sa_wb #(
    .DATA_LENGTH(32), .ADDR_LENGTH(32), .LINE_BITS(128), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid(valid), .rw(rw), .addr(addr), .wdata(wdata), .wmask(wmask),
    .ready(ready), .rvalid(rvalid), .rdata(rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
    .hit_count(hit_count), .miss_count(miss_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int m_hits   = 0;
  int m_misses = 0;

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [21:0] m_tag   [SETS][WAYS];
  int          m_rr    [SETS];

  // arch: what the CPU should observe; dram: what backing memory really holds.
  logic [127:0] arch [logic [31:0]];
  logic [127:0] dram [logic [31:0]];
  logic [31:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void ensure_line(input logic [31:0] la);
    logic [127:0] v;
    if (!arch.exists(la)) begin
      v = rand_line();
      arch[la] = v;
      dram[la] = v;
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
    end
    m_hits   = 0;
    m_misses = 0;
    foreach (arch[k]) arch[k] = dram[k];
  endfunction

  function automatic bit model_hits(input logic [31:0] a);
    int s;
    s = int'(a[9:4]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:10]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] wm, output bit hit, output bit wb,
                              output logic [31:0] wb_addr, output logic [127:0] wb_data,
                              output logic [31:0] rd_word);
    int s;
    int wi;
    int way;
    bit any_free;
    logic [31:0]  la;
    logic [127:0] line;
    s = int'(a[9:4]);
    wi = int'(a[3:2]);
    la = {a[31:4], 4'b0};
    way = -1;
    any_free = 1'b0;
    wb = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    ensure_line(la);
    for (int k = 0; k < WAYS; k++)
      if (m_valid[s][k] && m_tag[s][k] == a[31:10]) way = k;
    hit = (way >= 0);
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      for (int k = WAYS - 1; k >= 0; k--)
        if (!m_valid[s][k]) begin
          way = k;
          any_free = 1'b1;
        end
      if (!any_free) begin
        way = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      if (m_valid[s][way] && m_dirty[s][way]) begin
        wb = 1'b1;
        wb_addr = {m_tag[s][way], a[9:4], 4'b0};
        wb_data = arch[wb_addr];
      end
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way]   = a[31:10];
    end
    line = arch[la];
    rd_word = line[wi*32 +: 32];
    if (w) begin
      line[wi*32 +: 32] = (rd_word & ~wm) | (wd & wm);
      arch[la] = line;
      m_dirty[s][way] = 1'b1;
    end
  endtask

  // Acts as memory for one line transfer; entered and left on a falling edge.
  task automatic serve(input bit exp_rw, input logic [31:0] exp_addr, input logic [127:0] exp_data);
    int n;
    int d;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("mreq_valid", mem_req_valid, 1);
    check("mreq_rw", mem_req_rw, exp_rw);
    check("mreq_addr", mem_req_addr, exp_addr);
    if (exp_rw) begin
      check("mreq_wdata", mem_req_data, exp_data);
      last_wb_addr = mem_req_addr;
      last_wb_data = mem_req_data;
      dram[exp_addr] = mem_req_data;
    end
    d = $urandom_range(0, 2);
    repeat (d) begin
      @(negedge clk);
      check("mreq_hold", {mem_req_valid, mem_req_rw, mem_req_addr}, {1'b1, exp_rw, exp_addr});
    end
    mem_res_ready = 1'b1;
    mem_res_data  = exp_rw ? rand_line() : dram[exp_addr];
    @(negedge clk);
    mem_res_ready = 1'b0;
    mem_res_data  = rand_line();
  endtask

  task automatic cpu_access(input bit w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] wm, output logic [31:0] got);
    bit hit;
    bit wb;
    logic [31:0]  wba;
    logic [31:0]  exp_rd;
    logic [127:0] wbd;
    model_access(w, a, wd, wm, hit, wb, wba, wbd, exp_rd);
    check("ready_idle", ready, 1);
    valid = 1'b1; rw = w; addr = a; wdata = wd; wmask = wm;
    @(negedge clk);
    valid = 1'b0;
    if (!hit) begin
      check("miss_rvalid", rvalid, 0);
      check("miss_ready", ready, 0);
      if (wb) serve(1'b1, wba, wbd);
      serve(1'b0, {a[31:4], 4'b0}, '0);
    end
    check("resp_rvalid", rvalid, 1);
    check("resp_ready", ready, 1);
    check("resp_mreq_idle", mem_req_valid, 0);
    got = rdata;
    if (!w) check("resp_rdata", rdata, exp_rd);
    @(negedge clk);
  endtask

  // Two hitting requests on consecutive edges; the second is a read.
  task automatic cpu_b2b(input bit w1, input logic [31:0] a1, input logic [31:0] wd1,
                         input logic [31:0] wm1, input logic [31:0] a2, output logic [31:0] got2);
    bit h1, h2, wb1, wb2;
    logic [31:0]  wba1, wba2, e1, e2;
    logic [127:0] wbd1, wbd2;
    model_access(w1, a1, wd1, wm1, h1, wb1, wba1, wbd1, e1);
    model_access(1'b0, a2, 32'h0, 32'h0, h2, wb2, wba2, wbd2, e2);
    check("b2b_ready_idle", ready, 1);
    valid = 1'b1; rw = w1; addr = a1; wdata = wd1; wmask = wm1;
    @(negedge clk);
    check("b2b_rvalid1", rvalid, 1);
    check("b2b_ready1", ready, 1);
    if (!w1) check("b2b_rdata1", rdata, e1);
    rw = 1'b0; addr = a2; wdata = '0; wmask = '0;
    @(negedge clk);
    valid = 1'b0;
    check("b2b_rvalid2", rvalid, 1);
    check("b2b_rdata2", rdata, e2);
    check("b2b_no_mreq", mem_req_valid, 0);
    got2 = rdata;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] v;
    logic [31:0]  got;
    logic [31:0]  a, a2, wd, wm;
    bit           w;

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mreq_valid", mem_req_valid, 0);
    check("rst_mreq_rw", mem_req_rw, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss and refill
    v = rand_line();
    v[31:0] = 32'h1111_1111;
    arch[32'h100] = v;
    dram[32'h100] = v;
    cpu_access(1'b0, 32'h100, '0, '0, got);
    check("cold_rdata", got, 32'h1111_1111);
    check("cold_miss_count", miss_count, 1);
    check("cold_hit_count", hit_count, 0);

    cpu_b2b(1'b0, 32'h100, '0, '0, 32'h104, got);
    check("b2b_hit_count", hit_count, 2);

    cpu_access(1'b1, 32'h100, 32'hAB, 32'h0000_00FF, got);
    cpu_access(1'b0, 32'h100, '0, '0, got);
    check("masked_write_rdata", got, 32'h1111_11AB);

    // Fill set 16, then evict the dirty line in way 0
    cpu_access(1'b0, 32'h500, '0, '0, got);
    cpu_access(1'b0, 32'h900, '0, '0, got);
    check("evict_wb_addr", last_wb_addr, 32'h100);
    check("evict_wb_word0", last_wb_data[31:0], 32'h1111_11AB);
    cpu_access(1'b0, 32'h500, '0, '0, got);
    check("evict_way1_kept", hit_count, 5);

    // Same-cycle write hit and read of the same word
    cpu_access(1'b0, 32'h104, '0, '0, got);
    cpu_b2b(1'b1, 32'h104, 32'h22, 32'hFFFF_FFFF, 32'h104, got);
    check("wr_then_rd_forward", got, 32'h22);

    for (int i = 0; i < 160; i++) begin
      a  = {22'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      a2 = ($urandom_range(0, 1) == 1) ? a
           : {22'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: wm = 32'hFFFF_FFFF;
        1: wm = 32'h0000_00FF;
        2: wm = 32'hFF00_FF00;
        default: wm = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0 && model_hits(a) && model_hits(a2))
        cpu_b2b(w, a, wd, wm, a2, got);
      else
        cpu_access(w, a, wd, wm, got);
    end
    check("rand_hit_count", hit_count, 32'(m_hits));
    check("rand_miss_count", miss_count, 32'(m_misses));

    // Reset while a refill is outstanding
    valid = 1'b1; rw = 1'b0; addr = 32'h2280; wdata = '0; wmask = '0;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("alloc_issued", mem_req_valid, 1);
    check("alloc_issued_addr", mem_req_addr, 32'h2280);
    rst_n = 1'b0;
    #1;
    check("abort_mreq_valid", mem_req_valid, 0);
    check("abort_mreq_rw", mem_req_rw, 0);
    check("abort_ready", ready, 0);
    check("abort_rvalid", rvalid, 0);
    check("abort_rdata", rdata, 0);
    check("abort_hit_count", hit_count, 0);
    check("abort_miss_count", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mem_res_ready = 1'b1;
    mem_res_data  = rand_line();
    @(negedge clk);
    mem_res_ready = 1'b0;
    check("stray_res_mreq", mem_req_valid, 0);
    check("stray_res_ready", ready, 1);
    check("stray_res_rvalid", rvalid, 0);
    cpu_access(1'b0, 32'h100, '0, '0, got);
    check("post_reset_miss", miss_count, 1);
    check("post_reset_hits", hit_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
